// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// fifo_rd_pkg : shared types and constants for the FIFO read-side drain stage
// Revision    : 1.0
// ============================================================================
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } rd_occ_e;

  localparam int RD_BUF_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// ============================================================================
// rd_skid_buf : two-entry in-order buffer with registered valid/data outputs
// Revision    : 1.0
// ============================================================================
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occ_o
);

  rd_occ_e          state_q, state_d;
  logic             head_q, head_d;
  logic             wr_idx;
  logic [WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [RD_BUF_DEPTH];
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    mem_d   = mem_q;
    // Tail slot is head+occ mod 2; in TWO with a simultaneous pop that is the slot being freed.
    wr_idx  = (state_q == ONE) ? ~head_q : head_q;
    if (push_i) mem_d[wr_idx] = push_data_i;
    if (pop_i)  head_d = ~head_q;
    case (state_q)
      EMPTY: if (push_i) state_d = ONE;
      ONE: begin
        if (push_i && !pop_i)      state_d = TWO;
        else if (!push_i && pop_i) state_d = EMPTY;
      end
      TWO:     if (!push_i && pop_i) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    valid_d = (state_d != EMPTY);
    data_d  = mem_d[head_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
      mem_q   <= '{default: '0};
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      mem_q   <= mem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign occ_o   = state_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && state_q == TWO));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stage.sv
`default_nettype none
// ============================================================================
// fifo_rd_stage : drains a synchronous FIFO into a valid/ready stream
// Revision      : 1.0
// ============================================================================
module fifo_rd_stage
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_r_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] xfer_count
);

  logic             inflight_q;
  logic [CNT_W-1:0] xfer_q;
  logic [1:0]       w_occ;
  logic             w_pop;
  logic [2:0]       w_fill;

  assign w_pop  = m_valid && m_ready;
  // Credit seen by the next arrival: stored words plus the word already in flight, less this cycle's pop.
  assign w_fill = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign fifo_r_en = !rst && !fifo_empty && (w_fill < 3'(RD_BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      xfer_q     <= '0;
    end else begin
      inflight_q <= fifo_r_en;
      if (w_pop) xfer_q <= xfer_q + CNT_W'(1);
    end
  end

  assign xfer_count = xfer_q;

  rd_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_data_i(fifo_data),
    .pop_i      (w_pop),
    .valid_o    (m_valid),
    .data_o     (m_data),
    .occ_o      (w_occ)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stage.sv
`default_nettype none
// ============================================================================
// tb_fifo_rd_stage : bench for fifo_rd_stage with a behavioural upstream FIFO
// Revision         : 1.0
// ============================================================================
module tb_fifo_rd_stage;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data  = '0;
  logic             fifo_r_en;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [CNT_W-1:0] xfer_count;

  logic             fifo_clr;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] fq[$];

  always #5 clk = ~clk;

  fifo_rd_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_r_en (fifo_r_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .xfer_count(xfer_count)
  );

  // Upstream synchronous FIFO: registered data_out and empty flag.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_r_en) begin
        if (fq.size() > 0) fifo_data <= fq.pop_front();
        else               fifo_data <= 8'hEE;
      end
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               outstanding = 0;
  bit               rst_seen = 0;
  bit               prev_stall = 0;
  int               cyc = 0;
  int               n_ren = 0, n_vld = 0, n_pop = 0;
  int               first_pop_cyc = -1, last_pop_cyc = -1;
  int               empty_fall_cyc = -1, first_vld_cyc = -1;
  logic [WIDTH-1:0] last_pop_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample and score at negedge, advance the model at posedge, return #1 later.
  task automatic tick();
    logic s_pop, s_ren;
    @(negedge clk);
    s_pop = !rst && m_valid && m_ready;
    s_ren = fifo_r_en;
    if (rst) begin
      chk("rst_r_en", fifo_r_en, 0);
      if (rst_seen) begin
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_count", xfer_count, 0);
      end
    end else begin
      chk("count", xfer_count, exp_cnt);
      chk("outstanding_le_2", (outstanding <= 2), 1);
      if (fifo_empty) chk("r_en_while_empty", fifo_r_en, 0);
      if (prev_stall) chk("hold_valid", m_valid, 1);
      if (m_valid) begin
        n_vld++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got 0x%0h, expected no valid word (cycle %0d)", m_data, cyc);
        end else begin
          chk("head_data", m_data, exp_q[0]);
          if (m_ready) void'(exp_q.pop_front());
        end
      end
      if (!fifo_empty && empty_fall_cyc < 0) empty_fall_cyc = cyc;
    end
    if (s_ren) n_ren++;
    if (s_pop) begin
      n_pop++;
      last_pop_data = m_data;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    prev_stall = !rst && m_valid && !m_ready;
    @(posedge clk);
    if (fifo_clr)   exp_q.delete();
    else if (wr_en) exp_q.push_back(wr_data);
    if (rst) begin
      exp_cnt     = '0;
      outstanding = 0;
    end else begin
      if (s_pop) exp_cnt = exp_cnt + 1'b1;
      outstanding = outstanding + int'(s_ren) - int'(s_pop);
    end
    rst_seen = rst;
    cyc++;
    #1;
  endtask

  task automatic drain(input int max_cyc);
    m_ready = 1'b1;
    wr_en   = 1'b0;
    for (int i = 0; i < max_cyc && (exp_q.size() > 0 || m_valid); i++) tick();
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_clr = 1'b1; wr_en = 1'b0;
    tick(); tick();
    rst = 1'b0; fifo_clr = 1'b0;
  endtask

  task automatic clr_stats();
    n_ren = 0; n_vld = 0; n_pop = 0;
    first_pop_cyc = -1; last_pop_cyc = -1;
    empty_fall_cyc = -1; first_vld_cyc = -1;
  endtask

  typedef struct {
    logic [7:0] first;
    int         n;
    int         mode;
    int         exp_pops;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[4];
  bit   ready_tog;

  initial begin
    vecs[0] = '{first: 8'h10, n: 4,  mode: 0, exp_pops: 4,  exp_last: 8'h13};
    vecs[1] = '{first: 8'h20, n: 7,  mode: 1, exp_pops: 7,  exp_last: 8'h26};
    vecs[2] = '{first: 8'h30, n: 3,  mode: 2, exp_pops: 3,  exp_last: 8'h32};
    vecs[3] = '{first: 8'hF0, n: 12, mode: 3, exp_pops: 12, exp_last: 8'hFB};

    // Reset held while the FIFO holds words
    rst = 1'b1; fifo_clr = 1'b1; wr_en = 1'b0; wr_data = '0; m_ready = 1'b1;
    tick();
    fifo_clr = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77; tick();
    wr_data = 8'h78; tick();
    wr_en = 1'b0; tick(); tick();
    rst = 1'b0;
    drain(20);

    // Streaming 0x01..0x08
    do_reset();
    clr_stats();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); tick();
    end
    drain(20);
    chk("first_word_latency", first_vld_cyc - empty_fall_cyc, 2);
    chk("stream_span", last_pop_cyc - first_pop_cyc, 7);
    chk("stream_pops", n_pop, 8);
    chk("stream_last", last_pop_data, 8'h08);
    chk("stream_count", xfer_count, 16'd8);

    // Backpressure for 10 cycles
    clr_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = (i < 6); wr_data = 8'hA0 + 8'(i); tick();
    end
    wr_en = 1'b0;
    chk("bp_r_en_pulses", n_ren, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_head", m_data, 8'hA0);
    chk("bp_fifo_left", fq.size(), 4);
    drain(30);
    chk("bp_pops", n_pop, 6);
    chk("bp_last", last_pop_data, 8'hA5);

    // Single word: one pop, one valid cycle
    clr_stats();
    m_ready = 1'b1;
    wr_en = 1'b1; wr_data = 8'h5A; tick();
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("single_r_en", n_ren, 1);
    chk("single_valid_cycles", n_vld, 1);
    chk("single_data", last_pop_data, 8'h5A);

    // Alternating ready over 16 random words
    clr_stats();
    ready_tog = 1'b1;
    for (int i = 0; i < 60 && (i < 16 || exp_q.size() > 0); i++) begin
      wr_en = (i < 16); wr_data = 8'($urandom);
      m_ready = ready_tog; ready_tog = !ready_tog;
      tick();
    end
    wr_en = 1'b0;
    chk("alt_pops", n_pop, 16);
    drain(10);

    // Table-driven scenarios
    foreach (vecs[v]) begin
      clr_stats();
      for (int k = 0; k < vecs[v].n + 20; k++) begin
        wr_en   = (k < vecs[v].n);
        wr_data = vecs[v].first + 8'(k);
        case (vecs[v].mode)
          0:       m_ready = 1'b1;
          1:       m_ready = (k % 3 != 0);
          2:       m_ready = (k >= 5);
          default: m_ready = 1'($urandom);
        endcase
        tick();
      end
      drain(40);
      chk("vec_pops", n_pop, vecs[v].exp_pops);
      chk("vec_last", last_pop_data, vecs[v].exp_last);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      wr_en = ($urandom_range(0, 9) < 6); wr_data = 8'($urandom);
      m_ready = 1'($urandom);
      tick();
    end
    drain(600);

    // Reset with words buffered and in flight
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i); tick();
    end
    do_reset();
    clr_stats();
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_valid_cycles", n_vld, 0);
    chk("midrst_r_en", n_ren, 0);
    chk("midrst_count", xfer_count, 16'd0);

    // Counter wrap
    m_ready = 1'b1;
    for (int i = 0; i < 70000 && exp_cnt != 16'hFFFF; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom); tick();
    end
    chk("count_at_ffff", xfer_count, 16'hFFFF);
    for (int i = 0; i < 10 && exp_cnt == 16'hFFFF; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom); tick();
    end
    chk("count_wrapped", xfer_count, 16'h0000);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
